// File: rtl/fir_bram_pkg.sv
// fir_bram_pkg
//   Shared constants, the cfg-side FSM state type and the address range
//   check for the FIR coefficient/data BRAM arbiter.
//   Contents:
//     DEPTH      words held in the BRAM
//     ADDR_W     byte address width
//     DATA_W     word width
//     MAX_WAIT   lost arbitration cycles before a cfg request is forced to win
//     CNT_W      width of the starvation counter
//     cfg_state_t  C_IDLE / C_RD / C_RSP
//     in_range()   1 when a byte address maps onto an existing word
package fir_bram_pkg;

  localparam int DEPTH    = 11;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_RD   = 2'd1,
    C_RSP  = 2'd2
  } cfg_state_t;

  // Byte offset bits [1:0] do not select a word, so only the word index is compared.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr[ADDR_W-1:2] < (ADDR_W-2)'(DEPTH));
  endfunction

endpackage

// File: rtl/fir_bram_starve_ctr.sv
// fir_bram_starve_ctr
//   Saturating count of consecutive cycles a cfg request has been waiting
//   without being granted. Only built when FIR_BRAM_STARVE_GUARD_EN is defined.
//   Ports:
//     clk        clock
//     reset      synchronous, active-high reset
//     waiting    cfg request valid this cycle and not granted
//     saturated  count has reached MAX_WAIT; cfg must win its next arbitration
module fir_bram_starve_ctr
  import fir_bram_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  output logic saturated
);

  logic [CNT_W-1:0] count;

  // Count lost cycles, saturating at MAX_WAIT; a grant or an idle cfg side clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {CNT_W{1'b0}};
    end else if (!waiting) begin
      count <= {CNT_W{1'b0}};
    end else if (count != CNT_W'(MAX_WAIT)) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign saturated = (count == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/fir_bram_arbiter.sv
// fir_bram_arbiter
//   Shares the single port of the FIR coefficient/data BRAM between the
//   AXI-Lite configuration path (read/write) and the FIR engine (streaming
//   reads). The engine has priority; with FIR_BRAM_STARVE_GUARD_EN defined a
//   cfg request that has lost MAX_WAIT cycles in a row is forced to win.
//   Without the macro the engine has strict priority.
//   Ports:
//     CLK, Reset                      clock, synchronous active-high reset
//     cfg_req_*                       cfg request (valid/ready, we, wstrb, addr, wdata)
//     cfg_rsp_*                       cfg response (valid/ready, rdata, err)
//     eng_req_valid/ready, eng_req_addr  engine read request
//     eng_rsp_valid, eng_rsp_rdata    engine read data, one cycle after grant
//     bram_EN/WE/A/Di/Resetn          BRAM controls, bram_Do BRAM read data
module fir_bram_arbiter
  import fir_bram_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cfg_req_valid,
  output logic              cfg_req_ready,
  input  logic              cfg_req_we,
  input  logic [3:0]        cfg_req_wstrb,
  input  logic [ADDR_W-1:0] cfg_req_addr,
  input  logic [DATA_W-1:0] cfg_req_wdata,
  output logic              cfg_rsp_valid,
  input  logic              cfg_rsp_ready,
  output logic [DATA_W-1:0] cfg_rsp_rdata,
  output logic              cfg_rsp_err,
  input  logic              eng_req_valid,
  output logic              eng_req_ready,
  input  logic [ADDR_W-1:0] eng_req_addr,
  output logic              eng_rsp_valid,
  output logic [DATA_W-1:0] eng_rsp_rdata,
  output logic              bram_EN,
  output logic [3:0]        bram_WE,
  output logic [ADDR_W-1:0] bram_A,
  output logic [DATA_W-1:0] bram_Di,
  input  logic [DATA_W-1:0] bram_Do,
  output logic              bram_Resetn
);

  cfg_state_t state;
  cfg_state_t state_next;

  logic cfg_idle;
  logic cfg_force;
  logic cfg_grant;
  logic eng_grant;
  logic cfg_in_range;
  logic eng_in_range;
  logic rd_hold;      // a read was granted last cycle; keep EN up for its output
  logic eng_hit;      // last engine grant was in range, so bram_Do is its data

  assign cfg_idle     = (state == C_IDLE);
  assign cfg_in_range = in_range(cfg_req_addr);
  assign eng_in_range = in_range(eng_req_addr);

`ifdef FIR_BRAM_STARVE_GUARD_EN
  logic cfg_waiting;
  assign cfg_waiting = cfg_req_valid && !cfg_grant;

  fir_bram_starve_ctr u_starve_ctr (
    .clk       (CLK),
    .reset     (Reset),
    .waiting   (cfg_waiting),
    .saturated (cfg_force)
  );
`else
  assign cfg_force = 1'b0;
`endif

  // Engine wins a tie unless the cfg side is starved; cfg can only win from C_IDLE.
  assign cfg_req_ready = !Reset && cfg_idle && (!eng_req_valid || cfg_force);
  assign eng_req_ready = !Reset && !(cfg_req_valid && cfg_idle && cfg_force);
  assign cfg_grant     = cfg_req_valid && cfg_req_ready;
  assign eng_grant     = eng_req_valid && eng_req_ready;

  // cfg FSM state register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= C_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // cfg FSM next state: in-range reads need one extra cycle for the BRAM output.
  always_comb begin
    state_next = state;
    case (state)
      C_IDLE: begin
        if (cfg_grant) begin
          state_next = (cfg_in_range && !cfg_req_we) ? C_RD : C_RSP;
        end else begin
          state_next = C_IDLE;
        end
      end
      C_RD:   state_next = C_RSP;
      C_RSP: begin
        if (cfg_rsp_ready) begin
          state_next = C_IDLE;
        end else begin
          state_next = C_RSP;
        end
      end
      default: state_next = C_IDLE;
    endcase
  end

  // cfg response payload: error flag at grant, read data captured while in C_RD.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cfg_rsp_rdata <= {DATA_W{1'b0}};
      cfg_rsp_err   <= 1'b0;
    end else if (cfg_grant) begin
      cfg_rsp_rdata <= {DATA_W{1'b0}};
      cfg_rsp_err   <= !cfg_in_range;
    end else if (state == C_RD) begin
      cfg_rsp_rdata <= bram_Do;
      cfg_rsp_err   <= cfg_rsp_err;
    end else begin
      cfg_rsp_rdata <= cfg_rsp_rdata;
      cfg_rsp_err   <= cfg_rsp_err;
    end
  end

  assign cfg_rsp_valid = (state == C_RSP);

  // Engine response timing and the EN hold after any in-range read.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      eng_rsp_valid <= 1'b0;
      eng_hit       <= 1'b0;
      rd_hold       <= 1'b0;
    end else begin
      eng_rsp_valid <= eng_grant;
      eng_hit       <= eng_grant && eng_in_range;
      rd_hold       <= (cfg_grant && cfg_in_range && !cfg_req_we) ||
                       (eng_grant && eng_in_range);
    end
  end

  // Out-of-range engine reads return zero instead of whatever the BRAM holds.
  assign eng_rsp_rdata = eng_hit ? bram_Do : {DATA_W{1'b0}};

  // BRAM port drive; out-of-range grants never touch the BRAM.
  always_comb begin
    bram_EN = 1'b0;
    bram_WE = 4'b0000;
    bram_A  = {ADDR_W{1'b0}};
    bram_Di = {DATA_W{1'b0}};
    if (cfg_grant && cfg_in_range) begin
      bram_EN = 1'b1;
      bram_A  = cfg_req_addr;
      if (cfg_req_we) begin
        bram_WE = cfg_req_wstrb;
        bram_Di = cfg_req_wdata;
      end else begin
        bram_WE = 4'b0000;
      end
    end else if (eng_grant && eng_in_range) begin
      bram_EN = 1'b1;
      bram_A  = eng_req_addr;
    end else begin
      bram_EN = rd_hold && !Reset;
    end
  end

  assign bram_Resetn = ~Reset;

endmodule

// File: tb/tb_fir_bram_arbiter.sv
// tb_fir_bram_arbiter
//   Self-checking bench for fir_bram_arbiter with a behavioural BRAM and a
//   transaction-level reference model (memory array, outstanding-request
//   flag, response countdown, wait counter) checked every cycle.
module tb_fir_bram_arbiter;
  import fir_bram_pkg::*;

`ifdef FIR_BRAM_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              Reset = 1'b1;
  logic              cfg_req_valid = 1'b0;
  logic              cfg_req_ready;
  logic              cfg_req_we = 1'b0;
  logic [3:0]        cfg_req_wstrb = 4'h0;
  logic [ADDR_W-1:0] cfg_req_addr = '0;
  logic [DATA_W-1:0] cfg_req_wdata = '0;
  logic              cfg_rsp_valid;
  logic              cfg_rsp_ready = 1'b0;
  logic [DATA_W-1:0] cfg_rsp_rdata;
  logic              cfg_rsp_err;
  logic              eng_req_valid = 1'b0;
  logic              eng_req_ready;
  logic [ADDR_W-1:0] eng_req_addr = '0;
  logic              eng_rsp_valid;
  logic [DATA_W-1:0] eng_rsp_rdata;
  logic              bram_EN;
  logic [3:0]        bram_WE;
  logic [ADDR_W-1:0] bram_A;
  logic [DATA_W-1:0] bram_Di;
  logic [DATA_W-1:0] bram_Do;
  logic              bram_Resetn;

  int vectors = 0;
  int miscompares = 0;

  fir_bram_arbiter dut (
    .CLK(CLK), .Reset(Reset),
    .cfg_req_valid(cfg_req_valid), .cfg_req_ready(cfg_req_ready),
    .cfg_req_we(cfg_req_we), .cfg_req_wstrb(cfg_req_wstrb),
    .cfg_req_addr(cfg_req_addr), .cfg_req_wdata(cfg_req_wdata),
    .cfg_rsp_valid(cfg_rsp_valid), .cfg_rsp_ready(cfg_rsp_ready),
    .cfg_rsp_rdata(cfg_rsp_rdata), .cfg_rsp_err(cfg_rsp_err),
    .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready),
    .eng_req_addr(eng_req_addr), .eng_rsp_valid(eng_rsp_valid),
    .eng_rsp_rdata(eng_rsp_rdata),
    .bram_EN(bram_EN), .bram_WE(bram_WE), .bram_A(bram_A), .bram_Di(bram_Di),
    .bram_Do(bram_Do), .bram_Resetn(bram_Resetn)
  );

  always #5 CLK = ~CLK;

  // Behavioural BRAM: read-first, registered output gated by EN, cleared by Resetn.
  logic [DATA_W-1:0] ram [0:DEPTH-1];
  always @(posedge CLK) begin
    if (!bram_Resetn) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      bram_Do <= '0;
    end else if (bram_EN) begin
      if (int'(bram_A[ADDR_W-1:2]) < DEPTH) begin
        bram_Do <= ram[int'(bram_A[ADDR_W-1:2])];
        for (int b = 0; b < 4; b++)
          if (bram_WE[b]) ram[int'(bram_A[ADDR_W-1:2])][8*b +: 8] <= bram_Di[8*b +: 8];
      end else begin
        bram_Do <= 32'hBAD0_BAD0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [0:DEPTH-1];
  bit          m_init = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_rsp_valid = 1'b0;
  bit          m_rsp_wait = 1'b0;
  logic [31:0] m_rsp_rdata = '0;
  bit          m_rsp_err = 1'b0;
  int          m_starve = 0;
  bit          m_eng_valid = 1'b0;
  logic [31:0] m_eng_data = '0;
  bit          m_rd_prev = 1'b0;

  // Compare this cycle's outputs, then advance the model across the coming edge.
  task automatic check_and_advance();
    int cw, ew;
    bit c_in, e_in, forced, exp_cr, exp_er, c_hs, e_hs, exp_en;
    logic [3:0] exp_we;
    cw = int'(cfg_req_addr[ADDR_W-1:2]);
    ew = int'(eng_req_addr[ADDR_W-1:2]);
    c_in = cw < DEPTH;
    e_in = ew < DEPTH;
    forced = GUARD && (m_starve >= MAX_WAIT);
    exp_cr = !Reset && !m_busy && (!eng_req_valid || forced);
    exp_er = !Reset && !(cfg_req_valid && !m_busy && forced);
    c_hs = cfg_req_valid && exp_cr;
    e_hs = eng_req_valid && exp_er;
    if (m_init) begin
      chk("cfg_req_ready", 32'(cfg_req_ready), 32'(exp_cr));
      chk("eng_req_ready", 32'(eng_req_ready), 32'(exp_er));
      chk("cfg_rsp_valid", 32'(cfg_rsp_valid), 32'(m_rsp_valid));
      if (m_rsp_valid) begin
        chk("cfg_rsp_rdata", cfg_rsp_rdata, m_rsp_rdata);
        chk("cfg_rsp_err", 32'(cfg_rsp_err), 32'(m_rsp_err));
      end
      chk("eng_rsp_valid", 32'(eng_rsp_valid), 32'(m_eng_valid));
      if (m_eng_valid) chk("eng_rsp_rdata", eng_rsp_rdata, m_eng_data);
      exp_en = !Reset && ((c_hs && c_in) || (e_hs && e_in) || m_rd_prev);
      exp_we = (c_hs && c_in && cfg_req_we) ? cfg_req_wstrb : 4'h0;
      chk("bram_EN", 32'(bram_EN), 32'(exp_en));
      chk("bram_WE", 32'(bram_WE), 32'(exp_we));
      if (c_hs && c_in) chk("bram_A_cfg", 32'(bram_A), 32'(cfg_req_addr));
      if (c_hs && c_in && cfg_req_we) chk("bram_Di", bram_Di, cfg_req_wdata);
      if (e_hs && e_in) chk("bram_A_eng", 32'(bram_A), 32'(eng_req_addr));
      chk("bram_Resetn", 32'(bram_Resetn), 32'(!Reset));
    end
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_busy = 0; m_rsp_valid = 0; m_rsp_wait = 0; m_rsp_rdata = '0; m_rsp_err = 0;
      m_starve = 0; m_eng_valid = 0; m_eng_data = '0; m_rd_prev = 0; m_init = 1;
    end else begin
      if (!cfg_req_valid || c_hs) m_starve = 0;
      else if (m_starve < MAX_WAIT) m_starve++;
      if (m_rsp_valid && cfg_rsp_ready) begin m_rsp_valid = 0; m_busy = 0; end
      if (m_rsp_wait) begin m_rsp_wait = 0; m_rsp_valid = 1; end
      if (c_hs) begin
        m_busy = 1; m_rsp_err = !c_in; m_rsp_rdata = '0;
        if (c_in && !cfg_req_we) begin
          m_rsp_rdata = m_mem[cw]; m_rsp_wait = 1;
        end else begin
          m_rsp_valid = 1;
          if (c_in)
            for (int b = 0; b < 4; b++)
              if (cfg_req_wstrb[b]) m_mem[cw][8*b +: 8] = cfg_req_wdata[8*b +: 8];
        end
      end
      m_eng_valid = e_hs;
      m_eng_data = (e_hs && e_in) ? m_mem[ew] : 32'h0;
      m_rd_prev = (c_hs && c_in && !cfg_req_we) || (e_hs && e_in);
    end
  endtask

  initial forever begin
    @(negedge CLK);
    check_and_advance();
  end

  // ---------------- stimulus helpers ----------------
  task automatic cfg_txn(input logic we, input logic [3:0] strb, input logic [11:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
    bit g, v;
    int n;
    rdata = 32'hFFFF_FFFF; err = 1'bx; lat = -1;
    @(posedge CLK); #1;
    cfg_req_valid = 1; cfg_req_we = we; cfg_req_wstrb = strb;
    cfg_req_addr = addr; cfg_req_wdata = wdata; cfg_rsp_ready = 0;
    g = 0; n = 0;
    while (!g && n < 200) begin
      @(negedge CLK); g = cfg_req_ready; n++;
      if (!g) begin @(posedge CLK); #1; end
    end
    chk("cfg_grant_seen", 32'(g), 32'd1);
    @(posedge CLK); #1;
    cfg_req_valid = 0;
    if (!g) return;
    cfg_rsp_ready = 1; lat = 0; v = 0;
    while (!v && lat < 50) begin
      @(negedge CLK); lat++; v = cfg_rsp_valid;
      if (!v) begin @(posedge CLK); #1; end
    end
    chk("cfg_rsp_seen", 32'(v), 32'd1);
    rdata = cfg_rsp_rdata; err = cfg_rsp_err;
    @(posedge CLK); #1;
    cfg_rsp_ready = 0;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  wstrb;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, n;
    bit g, cr, erd;

    vecs[0] = '{1'b1, 4'hF, 12'h000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1};
    vecs[1] = '{1'b1, 4'h2, 12'h000, 32'h1234_5678, 32'h0000_0000, 1'b0, 1};
    vecs[2] = '{1'b0, 4'h0, 12'h000, 32'h0000_0000, 32'hFFFF_56FF, 1'b0, 2};
    vecs[3] = '{1'b1, 4'hF, 12'h008, 32'h0000_00A5, 32'h0000_0000, 1'b0, 1};
    vecs[4] = '{1'b0, 4'h0, 12'h008, 32'h0000_0000, 32'h0000_00A5, 1'b0, 2};
    vecs[5] = '{1'b0, 4'h0, 12'h02C, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
    vecs[6] = '{1'b1, 4'hF, 12'h02C, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1};
    vecs[7] = '{1'b1, 4'hF, 12'h028, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1};
    vecs[8] = '{1'b0, 4'h0, 12'h02B, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 2};
    vecs[9] = '{1'b0, 4'h0, 12'hFFC, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};

    // Reset values
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_cfg_req_ready", 32'(cfg_req_ready), 32'd0);
    chk("rst_eng_req_ready", 32'(eng_req_ready), 32'd0);
    chk("rst_cfg_rsp_valid", 32'(cfg_rsp_valid), 32'd0);
    chk("rst_cfg_rsp_err", 32'(cfg_rsp_err), 32'd0);
    chk("rst_cfg_rsp_rdata", cfg_rsp_rdata, 32'd0);
    chk("rst_eng_rsp_valid", 32'(eng_rsp_valid), 32'd0);
    chk("rst_bram_EN", 32'(bram_EN), 32'd0);
    chk("rst_bram_WE", 32'(bram_WE), 32'd0);
    chk("rst_bram_A", 32'(bram_A), 32'd0);
    chk("rst_bram_Di", bram_Di, 32'd0);
    @(posedge CLK); #1;
    Reset = 0;

    // Directed cfg vectors
    for (int i = 0; i < NV; i++) begin
      cfg_txn(vecs[i].we, vecs[i].wstrb, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Taps 1..11, then a back-to-back engine stream
    for (int k = 0; k < DEPTH; k++) cfg_txn(1'b1, 4'hF, 12'(k * 4), 32'(k + 1), rd, er, lat);
    for (int k = 0; k <= DEPTH; k++) begin
      @(posedge CLK); #1;
      eng_req_valid = (k < DEPTH);
      eng_req_addr = 12'(k * 4);
      if (k > 0) begin
        @(negedge CLK);
        chk($sformatf("stream%0d_valid", k), 32'(eng_rsp_valid), 32'd1);
        chk($sformatf("stream%0d_rdata", k), eng_rsp_rdata, 32'(k));
      end
    end

    // Contention between continuous engine traffic and one cfg read
    @(posedge CLK); #1;
    eng_req_valid = 1; eng_req_addr = 12'h000;
    cfg_req_valid = 1; cfg_req_we = 0; cfg_req_addr = 12'h008; cfg_rsp_ready = 1;
    n = 0; g = 0;
    while (!g && n < 20) begin
      @(negedge CLK); n++; g = cfg_req_ready;
      @(posedge CLK); #1;
      eng_req_addr = 12'($urandom_range(0, DEPTH - 1) * 4);
    end
`ifdef FIR_BRAM_STARVE_GUARD_EN
    chk("starve_granted", 32'(g), 32'd1);
    chk("starve_grant_cycle", 32'(n), 32'd5);
`else
    chk("strict_never_granted", 32'(g), 32'd0);
    eng_req_valid = 0;
    @(negedge CLK);
    g = cfg_req_ready;
    chk("idle_engine_grant", 32'(g), 32'd1);
    @(posedge CLK); #1;
`endif
    cfg_req_valid = 0; eng_req_valid = 0;
    repeat (4) @(posedge CLK);
    #1 cfg_rsp_ready = 0;

    // Reset while a cfg read sits in C_RD
    @(posedge CLK); #1;
    cfg_req_valid = 1; cfg_req_we = 0; cfg_req_addr = 12'h010;
    @(negedge CLK);
    chk("rstrd_grant", 32'(cfg_req_ready), 32'd1);
    @(posedge CLK); #1;
    cfg_req_valid = 0; Reset = 1;
    @(negedge CLK);
    chk("rstrd_ready_c1", 32'(cfg_req_ready), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rstrd_rsp_valid", 32'(cfg_rsp_valid), 32'd0);
    chk("rstrd_ready_c2", 32'(cfg_req_ready), 32'd0);
    @(posedge CLK); #1;
    Reset = 0;
    for (int k = 0; k < DEPTH; k++) begin
      cfg_txn(1'b0, 4'h0, 12'(k * 4), 32'h0, rd, er, lat);
      chk($sformatf("cleared_word%0d", k), rd, 32'h0);
    end

    // Randomized traffic, checked cycle by cycle by the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      cr = cfg_req_ready; erd = eng_req_ready;
      @(posedge CLK); #1;
      if (cfg_req_valid && cr) cfg_req_valid = 0;
      if (!cfg_req_valid && $urandom_range(0, 3) == 0) begin
        cfg_req_valid = 1;
        cfg_req_we = 1'($urandom_range(0, 1));
        cfg_req_wstrb = 4'($urandom_range(0, 15));
        cfg_req_addr = 12'($urandom_range(0, 13) * 4 + $urandom_range(0, 3));
        cfg_req_wdata = $urandom;
      end
      if (!eng_req_valid || erd) begin
        eng_req_valid = ($urandom_range(0, 2) != 0);
        eng_req_addr = 12'($urandom_range(0, 12) * 4);
      end
      cfg_rsp_ready = 1'($urandom_range(0, 1));
    end
    @(posedge CLK); #1;
    cfg_req_valid = 0; eng_req_valid = 0; cfg_rsp_ready = 1;
    repeat (5) @(posedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
